fixedpoint_accumulator: RTL and testbench
=========================================

# fixedpoint_accumulator

Parametrised signed fixed-point accumulator for the MulAdd_Acc datapath. It sums a framed stream of two's-complement operands, for example multiplier products in S.INT.FRAC format, into a wide accumulator. Overflow is handled by saturation or by wrap, selected with a parameter. At the end of each frame it presents one registered result, with a beat count and an overflow flag, on a valid/ready output port.

## Interface
- WIDTH_INPUT, 16: operand width (S + 6 INT + 9 FRAC by default).
- WIDTH_ACC, 32: accumulator and result width; must be ≥ WIDTH_INPUT.
- WIDTH_CNT, 8: beat-counter width.
- SATURATE, 1: 1 clamps to the signed min/max of WIDTH_ACC; 0 wraps modulo 2^WIDTH_ACC.

Ports:
- clk_i  in  1  sole clock. One clock; reset is synchronous and active-low.
- rst_ni  in  1  synchronous active-low reset.
- data_i  in  WIDTH_INPUT  signed operand; binary point matches the output.
- valid_i  in  1  operand valid.
- last_i  in  1  marks the final beat of a frame; qualified by valid_i.
- ready_o  out  1  accumulator can accept a beat.
- data_o  out  WIDTH_ACC  frame sum.
- count_o  out  WIDTH_CNT  beats accepted in the frame; saturates at all-ones.
- ovf_o  out  1  sticky: at least one add in the frame overflowed.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.

## Operation
- FSM states:
  - ACC: accepting beats; ready_o=1, valid_o=0.
  - OUT: holding the result; ready_o=0, valid_o=1.
- Transitions:
  - ACC→OUT when valid_i&last_i is accepted.
  - OUT→ACC when valid_i... no: OUT→ACC when valid_o&ready_i.
  - Otherwise the state holds.
- Beat acceptance: a beat is accepted when valid_i&ready_o. On acceptance:
  - acc ← f(acc + sext(data_i));
  - count ← count+1, stopping at 2^WIDTH_CNT−1;
  - ovf ← ovf | overflow.
- Add arithmetic:
  - The sum is formed at WIDTH_ACC+1 bits.
  - Overflow means the top two bits of the WIDTH_ACC+1-bit sum differ.
  - f() clamps to 2^(WIDTH_ACC−1)−1 on positive overflow and −2^(WIDTH_ACC−1) on negative overflow when SATURATE=1.
  - f() truncates (wraps) when SATURATE=0.
  - ovf_o is set on overflow in both modes.
- After saturation the accumulator continues from the clamped value. It does not re-derive an exact sum.
- A beat with last_i=1 is summed like any other beat; the result includes it.
- last_i with valid_i=0 is ignored.
- On the output handshake, acc, count and ovf clear to 0 in the same edge, and the FSM returns to ACC.
- In OUT, data_o, count_o and ovf_o are stable until the handshake.
- Frames of length 1 are legal.
- There are no empty frames: a frame needs at least one last beat.

## Timing
- Reset, on any rising edge with rst_ni=0:
  - state=ACC, acc=0, count=0, ovf=0;
  - outputs: ready_o=1, valid_o=0, data_o=0, count_o=0, ovf_o=0.
- Reset asserted mid-frame or in OUT discards the frame and the pending result. There is no partial output.
- Throughput: one beat per cycle in ACC.
- Latency: a last beat accepted at edge N gives valid_o=1 with the final data_o after edge N, in the next cycle.
- Handshake bubble: an output handshake at edge M makes ready_o=1 after M. No beat is accepted in the handshake cycle, so there is one bubble per frame.
- ready_o is a function of registered state only, with no combinational path from ready_i. valid_o is also registered-state only.
- valid_o is held until ready_i. Upstream may change data_i freely while ready_o=0.
- All outputs come straight from flops.

## Structure
- Package fixedpoint_pkg holds:
  - the state enum (ACC, OUT);
  - localparams for the default Q6.9 format (WIDTH_INTEGER=6, WIDTH_FRACTION=9);
  - a function returning the signed max/min for a given width.
- One sub-module, fixedpoint_sat_adder (combinational): a parametrised successor of the plain adder.
  - Inputs: two operands of width W, and SATURATE.
  - Outputs: sum of width W, and overflow.
  - The accumulator instantiates it with W=WIDTH_ACC, on acc and sext(data_i).
- Top level: FSM, acc/count/ovf registers, handshake logic.

## Test plan
- Basic frame, defaults: beats 0x0200, 0x0100, 0xFE00 with last on the third (1.0+0.5−1.0) → one cycle later valid_o=1, data_o=0x00000100, count_o=3, ovf_o=0.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o → data_o/count_o stable, ready_o=0 throughout, beats offered are not accepted. Release → next cycle ready_o=1 and acc cleared. Verify the next frame {0x0001 last} → data_o=1, count_o=1.
- Saturation, WIDTH_INPUT=16, WIDTH_ACC=16, SATURATE=1: 0x7FFF, 0x0001, 0xFFFF last → data_o=0x7FFE, ovf_o=1. Same stimulus with SATURATE=0 → data_o=0x7FFF, ovf_o=1 (wrap to 0x8000, then −1 gives 0x7FFF).
- Negative clamp, WIDTH_ACC=16, SATURATE=1: 0x8000, 0xFFFF last → data_o=0x8000, ovf_o=1.
- Count saturation, WIDTH_CNT=2: 5 beats of 0x0001 → count_o=3, data_o=5.
- Mid-frame reset: two beats accepted, then rst_ni=0 for one edge → all outputs at reset values. A following frame {0x0003 last} gives data_o=3, count_o=1.
- Random valid_i/ready_i throttling over 1000 frames, checked against a reference model: no lost or duplicated beats, and valid_o never drops before ready_i.

Source files
------------

// File: rtl/fixedpoint_pkg.sv
// Shared types and constants for the MulAdd_Acc fixed-point accumulator.
// Default operand format is S.Q6.9 (16 bits).
package fixedpoint_pkg;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  localparam int WIDTH_INTEGER  = 6;
  localparam int WIDTH_FRACTION = 9;
  localparam int WIDTH_Q        = 1 + WIDTH_INTEGER + WIDTH_FRACTION;

  // Signed extreme of a given width, returned sign-extended to 64 bits.
  function automatic logic [63:0] signed_limit(input int unsigned width, input logic want_min);
    logic [63:0] max_v;
    max_v = (64'd1 << (width - 32'd1)) - 64'd1;
    if (want_min) begin
      return ~max_v;
    end else begin
      return max_v;
    end
  endfunction

endpackage

// File: rtl/fixedpoint_sat_adder.sv
// Combinational W-bit signed adder with overflow detection and optional clamp
// to the signed range of W.
module fixedpoint_sat_adder
  import fixedpoint_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         saturate_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  localparam logic [63:0] MAX64 = signed_limit(W, 1'b0);
  localparam logic [63:0] MIN64 = signed_limit(W, 1'b1);

  logic [W-1:0] max_s;
  logic [W-1:0] min_s;
  logic [W:0]   wide_s;

  assign max_s  = MAX64[W-1:0];
  assign min_s  = MIN64[W-1:0];
  assign wide_s = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  // The extra top bit carries the true sign; disagreement with bit W-1 is overflow.
  assign ovf_o  = wide_s[W] ^ wide_s[W-1];

  always_comb begin
    sum_o = wide_s[W-1:0];
    if (ovf_o && saturate_i) begin
      if (wide_s[W]) begin
        sum_o = min_s;
      end else begin
        sum_o = max_s;
      end
    end else begin
      sum_o = wide_s[W-1:0];
    end
  end

endmodule

// File: rtl/fixedpoint_accumulator.sv
// Framed signed accumulator: sums beats until last, then holds one registered
// result (sum, beat count, sticky overflow) on a valid/ready output port.
module fixedpoint_accumulator
  import fixedpoint_pkg::*;
#(
  parameter int WIDTH_INPUT = WIDTH_Q,
  parameter int WIDTH_ACC   = 32,
  parameter int WIDTH_CNT   = 8,
  parameter int SATURATE    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH_INPUT-1:0] data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [WIDTH_ACC-1:0]   data_o,
  output logic [WIDTH_CNT-1:0]   count_o,
  output logic                   ovf_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam logic SAT_EN = (SATURATE != 0);

  state_e               state_q, state_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;

  logic [WIDTH_ACC-1:0] operand_ext_s;
  logic [WIDTH_ACC-1:0] sum_s;
  logic                 add_ovf_s;
  logic                 accept_s;
  logic                 handshake_s;

  assign accept_s      = valid_i & ready_q;
  assign handshake_s   = valid_q & ready_i;
  assign operand_ext_s = WIDTH_ACC'($signed(data_i));

  fixedpoint_sat_adder #(
    .W (WIDTH_ACC)
  ) u_adder (
    .a_i        (acc_q),
    .b_i        (operand_ext_s),
    .saturate_i (SAT_EN),
    .sum_o      (sum_s),
    .ovf_o      (add_ovf_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        if (accept_s && last_i) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (handshake_s) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Handshake flags are decoded from the next state so they leave from flops.
  always_comb begin
    ready_d = 1'b1;
    valid_d = 1'b0;
    case (state_d)
      ST_ACC: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
      ST_OUT: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
      end
      default: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (handshake_s) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept_s) begin
      acc_d = sum_s;
      if (cnt_q == {WIDTH_CNT{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + WIDTH_CNT'(1);
      end
      ovf_d = ovf_q | add_ovf_s;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = acc_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_fixedpoint_accumulator.sv
// Bench for fixedpoint_accumulator: four parameterisations share one stimulus
// stream; table vectors, corner sequences and a randomized model-checked run.
module tb_fixedpoint_accumulator;

  logic        clk;
  logic        rst_ni;
  logic [15:0] data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_i;

  // 0: defaults, 1: ACC16 saturate, 2: ACC16 wrap, 3: CNT2
  logic        r0, r1, r2, r3, v0, v1, v2, v3, f0, f1, f2, f3;
  logic [31:0] d0, d3;
  logic [15:0] d1, d2;
  logic [7:0]  c0, c1, c2;
  logic [1:0]  c3;

  logic        o_rdy [4];
  logic        o_vld [4];
  logic        o_ovf [4];
  logic [31:0] o_data[4];
  logic [7:0]  o_cnt [4];

  int cfg_wacc[4] = '{32, 16, 16, 32};
  int cfg_wcnt[4] = '{8, 8, 8, 2};
  bit cfg_sat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fixedpoint_accumulator u_def (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(r0), .data_o(d0), .count_o(c0), .ovf_o(f0), .valid_o(v0), .ready_i(ready_i));

  fixedpoint_accumulator #(.WIDTH_ACC(16), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(r1), .data_o(d1), .count_o(c1), .ovf_o(f1), .valid_o(v1), .ready_i(ready_i));

  fixedpoint_accumulator #(.WIDTH_ACC(16), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(r2), .data_o(d2), .count_o(c2), .ovf_o(f2), .valid_o(v2), .ready_i(ready_i));

  fixedpoint_accumulator #(.WIDTH_CNT(2)) u_cnt (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(r3), .data_o(d3), .count_o(c3), .ovf_o(f3), .valid_o(v3), .ready_i(ready_i));

  always_comb begin
    o_rdy[0] = r0;  o_rdy[1] = r1;  o_rdy[2] = r2;  o_rdy[3] = r3;
    o_vld[0] = v0;  o_vld[1] = v1;  o_vld[2] = v2;  o_vld[3] = v3;
    o_ovf[0] = f0;  o_ovf[1] = f1;  o_ovf[2] = f2;  o_ovf[3] = f3;
    o_data[0] = d0; o_data[1] = {16'h0000, d1}; o_data[2] = {16'h0000, d2}; o_data[3] = d3;
    o_cnt[0] = c0;  o_cnt[1] = c1;  o_cnt[2] = c2;  o_cnt[3] = {6'b000000, c3};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    @(negedge clk);
    data_i = d; valid_i = 1'b1; last_i = l; ready_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string name);
    int n;
    n = 0;
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0;
    while (!o_vld[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait_valid"}, 32'(n < 10), 32'd1);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_hs_ready"}, 32'(o_rdy[0]), 32'd1);
    chk({name, "_hs_count"}, 32'(o_cnt[0]), 32'd0);
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic chk_reset_all(input string name);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_rdy%0d", name, c), 32'(o_rdy[c]), 32'd1);
      chk($sformatf("%s_vld%0d", name, c), 32'(o_vld[c]), 32'd0);
      chk($sformatf("%s_data%0d", name, c), o_data[c], 32'd0);
      chk($sformatf("%s_cnt%0d", name, c), 32'(o_cnt[c]), 32'd0);
      chk($sformatf("%s_ovf%0d", name, c), 32'(o_ovf[c]), 32'd0);
    end
  endtask

  // Reference: stepwise signed sum with clamp or modular wrap at the target width.
  logic [15:0] frame_q[$];

  function automatic void fold(input int c, output logic [31:0] d, output logic [7:0] n,
                               output logic o);
    longint acc, span, maxv, minv;
    int cnt, cmax;
    span = longint'(1) <<< cfg_wacc[c];
    maxv = span / 2 - 1;
    minv = -(span / 2);
    cmax = (1 << cfg_wcnt[c]) - 1;
    acc = 0; cnt = 0; o = 1'b0;
    foreach (frame_q[i]) begin
      acc = acc + longint'($signed(frame_q[i]));
      if (acc > maxv) begin
        o = 1'b1;
        acc = cfg_sat[c] ? maxv : acc - span;
      end else if (acc < minv) begin
        o = 1'b1;
        acc = cfg_sat[c] ? minv : acc + span;
      end
      if (cnt < cmax) cnt++;
    end
    d = 32'(acc & (span - 1));
    n = 8'(cnt);
  endfunction

  typedef struct {
    logic [15:0] d;
    logic        v, l, r;
    logic        e_rdy, e_vld;
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] e_data[4];
  logic [7:0]  e_cnt [4];
  logic        e_ovf [4];
  bit          m_out;
  int          frames_done;
  int          cycles;

  initial begin
    rst_ni = 1'b0; data_i = 16'h0000; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_all("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    // Basic frame 1.0 + 0.5 - 1.0, 5 cycles of backpressure, then a length-1 frame.
    tbl[0]  = '{16'h0200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000200, 8'd1};
    tbl[1]  = '{16'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000300, 8'd2};
    tbl[2]  = '{16'hFE00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[3]  = '{16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[4]  = '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[5]  = '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[6]  = '{16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[7]  = '{16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 8'd3};
    tbl[8]  = '{16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 8'd0};
    tbl[9]  = '{16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 8'd1};
    tbl[10] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 8'd0};
    tbl[11] = '{16'h0009, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 8'd0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      data_i = tbl[i].d; valid_i = tbl[i].v; last_i = tbl[i].l; ready_i = tbl[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(o_rdy[0]), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(o_vld[0]), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_data", i), o_data[0], tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), 32'(o_cnt[0]), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(o_ovf[0]), 32'd0);
    end
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;

    // Positive overflow: clamp vs wrap at 16 bits, exact at 32 bits.
    beat(16'h7FFF, 1'b0); beat(16'h0001, 1'b0); beat(16'hFFFF, 1'b1);
    chk("pos_valid_sat", 32'(o_vld[1]), 32'd1);
    chk("pos_data_sat", o_data[1], 32'h00007FFE);
    chk("pos_ovf_sat", 32'(o_ovf[1]), 32'd1);
    chk("pos_data_wrap", o_data[2], 32'h00007FFF);
    chk("pos_ovf_wrap", 32'(o_ovf[2]), 32'd1);
    chk("pos_data_wide", o_data[0], 32'h00007FFF);
    chk("pos_ovf_wide", 32'(o_ovf[0]), 32'd0);
    handshake("pos");

    // Negative overflow.
    beat(16'h8000, 1'b0); beat(16'hFFFF, 1'b1);
    chk("neg_data_sat", o_data[1], 32'h00008000);
    chk("neg_ovf_sat", 32'(o_ovf[1]), 32'd1);
    chk("neg_data_wrap", o_data[2], 32'h00007FFF);
    chk("neg_ovf_wrap", 32'(o_ovf[2]), 32'd1);
    chk("neg_data_wide", o_data[0], 32'hFFFF7FFF);
    handshake("neg");

    // Beat counter saturation with a 2-bit counter.
    for (int i = 0; i < 5; i++) beat(16'h0001, (i == 4) ? 1'b1 : 1'b0);
    chk("cnt_sat_count", 32'(o_cnt[3]), 32'd3);
    chk("cnt_sat_data", o_data[3], 32'd5);
    chk("cnt_wide_count", 32'(o_cnt[0]), 32'd5);
    handshake("cnt");

    // Reset mid-frame, then a fresh frame.
    beat(16'h0003, 1'b0); beat(16'h0004, 1'b0);
    @(negedge clk);
    valid_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_all("midrst");
    @(negedge clk);
    rst_ni = 1'b1;
    beat(16'h0003, 1'b1);
    chk("midrst_next_data", o_data[0], 32'd3);
    chk("midrst_next_count", 32'(o_cnt[0]), 32'd1);
    handshake("midrst");

    // Reset while a result is pending.
    beat(16'h0007, 1'b1);
    chk("outrst_valid_before", 32'(o_vld[0]), 32'd1);
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_all("outrst");
    @(negedge clk);
    rst_ni = 1'b1;

    // Randomized throttling against the reference model.
    frame_q.delete();
    m_out = 1'b0;
    frames_done = 0;
    cycles = 0;
    while ((frames_done < 1000 || m_out) && cycles < 60000) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rnd_ready%0d", c), 32'(o_rdy[c]), 32'(!m_out));
        chk($sformatf("rnd_valid%0d", c), 32'(o_vld[c]), 32'(m_out));
        if (m_out) begin
          chk($sformatf("rnd_data%0d", c), o_data[c], e_data[c]);
          chk($sformatf("rnd_count%0d", c), 32'(o_cnt[c]), 32'(e_cnt[c]));
          chk($sformatf("rnd_ovf%0d", c), 32'(o_ovf[c]), 32'(e_ovf[c]));
        end
      end
      data_i  = 16'($urandom);
      valid_i = ($urandom_range(0, 99) < 70);
      last_i  = ($urandom_range(0, 3) == 0);
      ready_i = ($urandom_range(0, 99) < 60);
      if (!m_out) begin
        if (valid_i) begin
          frame_q.push_back(data_i);
          if (last_i) begin
            for (int c = 0; c < 4; c++) fold(c, e_data[c], e_cnt[c], e_ovf[c]);
            frame_q.delete();
            m_out = 1'b1;
            frames_done++;
          end
        end
      end else if (ready_i) begin
        m_out = 1'b0;
      end
      cycles++;
    end
    chk("rnd_budget", 32'(cycles < 60000), 32'd1);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    chk("rnd_final_ready", 32'(o_rdy[0]), 32'd1);
    chk("rnd_final_count", 32'(o_cnt[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
